riscv_perf_window_ctrl: RTL
===========================

// Module: riscv_perf_window_ctrl
// PURPOSE
//  Sequences fixed-length performance measurement windows for one RV32IM core: counts retired
//  instrs, stall cycles, branches and mispredicts, computes IPC / stall % / mispredict %, then
//  hands the result to the performance optimizer over a valid/ready report port. Sits between
//  pipeline event strobes and the optimizer; its threshold flags drive optimizer decisions.
// PARAMETERS
//  WINDOW_CYCLES       1024  cycles per window; power of 2, >=16
//  CNT_WIDTH           32    event counter width; also divider iterations
//  IPC_PRECISION       1000  IPC fixed-point scale (1.0 IPC = 1000)
//  IPC_TARGET          85    IPC target, percent of IPC_PRECISION
//  STALL_THRESHOLD     20    stall-rate flag threshold, percent
//  BRANCH_MISS_THRESH  10    mispredict-rate flag threshold, percent
// PORTS
//  clk_i           in   1          core clock; only clock
//  rst_i           in   1          synchronous, active-high reset
//  enable_i        in   1          run windows back-to-back while high
//  retire_cnt_i    in   2          instrs retired this cycle (0..2)
//  stall_i         in   1          pipeline stalled this cycle
//  branch_i        in   1          branch resolved this cycle
//  branch_miss_i   in   1          resolved branch mispredicted (ignored unless branch_i)
//  report_valid_o  out  1          report available
//  report_ready_i  in   1          optimizer accepts report
//  ipc_o           out  16         retired*IPC_PRECISION/WINDOW_CYCLES, saturates 16'hFFFF
//  stall_pct_o     out  8          stalls*100/WINDOW_CYCLES
//  bmiss_pct_o     out  8          misses*100/branches; 0 when branches==0
//  ipc_low_o       out  1          ipc_o < IPC_TARGET*IPC_PRECISION/100 (850)
//  stall_high_o    out  1          stall_pct_o > STALL_THRESHOLD
//  bmiss_high_o    out  1          bmiss_pct_o > BRANCH_MISS_THRESH
//  overrun_o       out  1          sticky: a window result was dropped; cleared by rst_i only
//  busy_o          out  1          FSM not IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, all counters 0, measure FSM IDLE, result FSM R_IDLE.
//  - Measure FSM IDLE->MEASURE on enable_i=1; window counter increments every MEASURE cycle.
//    Event counters accumulate same cycle as strobes; saturate at 2^CNT_WIDTH-1, no wrap.
//  - Last window cycle (count==WINDOW_CYCLES-1): counters snapshotted, cleared, and the next
//    window starts the following cycle if enable_i=1, else IDLE. Zero dead cycles between windows.
//  - enable_i=0 mid-window: window aborted, counters cleared, IDLE next cycle, no report.
//    Already-snapshotted result continues through DIVIDE/REPORT unaffected.
//  - Result FSM R_IDLE->DIVIDE on snapshot. IPC and stall % are multiply+shift by
//    log2(WINDOW_CYCLES). Mispredict % uses restoring divider, 1 quotient bit/cycle, exactly
//    CNT_WIDTH cycles; quotient clamps to 100. DIVIDE->REPORT; report_valid_o rises
//    CNT_WIDTH+1 cycles after last window cycle.
//  - REPORT: data/flag outputs stable while report_valid_o=1; transfer on valid&&ready;
//    valid drops next cycle -> R_IDLE. valid never deasserts without transfer.
//  - Snapshot while result FSM not R_IDLE: new result dropped, overrun_o set; held report kept.
//  - Snapshot and handshake same cycle: handshake completes, new snapshot accepted (no overrun).
//  - rst_i mid-operation: all state aborted, reset values next cycle.
// CONFIGURATION
//  RISCV_PERF_WIN_HYST_EN defined: each threshold flag sets only after 2 consecutive reported
//  windows exceed it and clears only after 2 consecutive below; one 2-bit history per flag,
//  updated on handshake. Undefined: flags are pure function of current report.
// TESTING (WINDOW_CYCLES=1024, CNT_WIDTH=32, ready held 1 unless noted)
//  1 retire_cnt_i=1 all cycles, no stall/branch -> ipc_o=1000, stall_pct_o=0, bmiss_pct_o=0,
//    flags 0, report_valid_o high 33 cycles after window end.
//  2 retire=1 on 768 cycles, stall_i on 256 -> ipc_o=750, stall_pct_o=25, ipc_low_o=1,
//    stall_high_o=1.
//  3 200 branches, 30 misses -> bmiss_pct_o=15, bmiss_high_o=1; 0 branches -> bmiss_pct_o=0.
//  4 report_ready_i=0 for 2 windows -> first report held unchanged, overrun_o=1, second
//    window's result never presented.
//  5 enable_i dropped at cycle 500 -> no report, busy_o=0 next cycle; re-enable -> full
//    window from zero.
//  6 rst_i during DIVIDE -> all outputs 0 next cycle, no report_valid_o afterwards.
//  7 (HYST_EN) stall 25%,25%,10%,10% windows -> stall_high_o 0,1,1,0.

Source files
------------

// File: rtl/riscv_perf_window_ctrl.sv
// Fixed-length performance window sequencer for one RV32IM core: counts events, derives IPC / stall % / mispredict %,
// and reports over valid/ready. Optional flag hysteresis is enabled by defining RISCV_PERF_WIN_HYST_EN.
module riscv_perf_window_ctrl #(
  parameter int unsigned WINDOW_CYCLES      = 1024,
  parameter int unsigned CNT_WIDTH          = 32,
  parameter int unsigned IPC_PRECISION      = 1000,
  parameter int unsigned IPC_TARGET         = 85,
  parameter int unsigned STALL_THRESHOLD    = 20,
  parameter int unsigned BRANCH_MISS_THRESH = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [1:0]  retire_cnt_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic        branch_miss_i,
  output logic        report_valid_o,
  input  logic        report_ready_i,
  output logic [15:0] ipc_o,
  output logic [7:0]  stall_pct_o,
  output logic [7:0]  bmiss_pct_o,
  output logic        ipc_low_o,
  output logic        stall_high_o,
  output logic        bmiss_high_o,
  output logic        overrun_o,
  output logic        busy_o
);

  localparam int unsigned LOG2W = $clog2(WINDOW_CYCLES);
  localparam int unsigned DCW   = $clog2(CNT_WIDTH);
  localparam int unsigned IPW   = CNT_WIDTH + 32;
  localparam int unsigned MW    = CNT_WIDTH + 7;

  localparam logic [IPW-1:0]       IPC_PREC_W  = IPW'(IPC_PRECISION);
  localparam logic [IPW-1:0]       PCT_W       = IPW'(100);
  localparam logic [MW-1:0]        PCT_M       = MW'(100);
  localparam logic [CNT_WIDTH-1:0] Q_MAX       = CNT_WIDTH'(100);
  localparam logic [15:0]          IPC_LOW_LIM = 16'(IPC_TARGET * IPC_PRECISION / 100);
  localparam logic [7:0]           STALL_TH    = 8'(STALL_THRESHOLD);
  localparam logic [7:0]           BMISS_TH    = 8'(BRANCH_MISS_THRESH);
  localparam logic [DCW-1:0]       DIV_LAST    = DCW'(CNT_WIDTH - 1);

  typedef enum logic {M_IDLE, M_MEASURE} m_state_t;
  typedef enum logic [1:0] {R_IDLE, R_DIVIDE, R_REPORT} r_state_t;

  m_state_t m_state_reg, m_state_next;
  r_state_t r_state_reg, r_state_next;
  logic     measuring, dividing;

  logic [LOG2W-1:0]     win_cnt_reg;
  logic [CNT_WIDTH-1:0] ret_cnt_reg, stall_cnt_reg, br_cnt_reg, miss_cnt_reg;
  logic [CNT_WIDTH-1:0] ret_sum, stall_sum, br_sum, miss_sum;
  logic                 last_cycle, snap_fire, snap_accept, load_snap, handshake, load_report;

  logic [CNT_WIDTH-1:0] snap_ret_reg, snap_stall_reg;
  logic [CNT_WIDTH-1:0] dvd_reg, rem_reg, dsr_reg;
  logic [CNT_WIDTH-2:0] q_reg;
  logic [DCW-1:0]       div_cnt_reg;
  logic                 div_ovf_reg, div_zero_reg;
  logic [MW-1:0]        mprod;
  logic [6:0]           mprod_hi;
  logic [CNT_WIDTH:0]   rem_shift;
  logic [CNT_WIDTH-1:0] rem_diff, rem_step, q_step;
  logic                 q_bit;

  logic [IPW-1:0] ipc_prod, ipc_shift, stall_prod, stall_shift;
  logic [15:0]    ipc_calc, ipc_reg;
  logic [7:0]     stall_calc, stall_reg, bmiss_calc, bmiss_reg;
  logic [2:0]     raw_calc, flag_calc, flags_reg;
  logic           overrun_reg;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a, input logic [1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, b};
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  // ---------------- measure FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) m_state_reg <= M_IDLE;
    else       m_state_reg <= m_state_next;
  end

  always_comb begin
    m_state_next = m_state_reg;
    case (m_state_reg)
      M_IDLE:    if (enable_i) m_state_next = M_MEASURE;
      M_MEASURE: if (!enable_i) m_state_next = M_IDLE;
      default:   m_state_next = M_IDLE;
    endcase
  end

  always_comb begin
    measuring = 1'b0;
    busy_o    = 1'b0;
    if (m_state_reg == M_MEASURE) begin
      measuring = 1'b1;
      busy_o    = 1'b1;
    end
  end

  assign last_cycle = measuring && (win_cnt_reg == '1);
  assign snap_fire  = last_cycle;

  // Sums include this cycle's strobes so the snapshot sees the final window cycle.
  assign ret_sum   = sat_add(ret_cnt_reg, retire_cnt_i);
  assign stall_sum = sat_add(stall_cnt_reg, {1'b0, stall_i});
  assign br_sum    = sat_add(br_cnt_reg, {1'b0, branch_i});
  assign miss_sum  = sat_add(miss_cnt_reg, {1'b0, branch_i & branch_miss_i});

  always_ff @(posedge clk_i) begin
    if (rst_i || !measuring || !enable_i || last_cycle) begin
      win_cnt_reg   <= '0;
      ret_cnt_reg   <= '0;
      stall_cnt_reg <= '0;
      br_cnt_reg    <= '0;
      miss_cnt_reg  <= '0;
    end else begin
      win_cnt_reg   <= win_cnt_reg + LOG2W'(1);
      ret_cnt_reg   <= ret_sum;
      stall_cnt_reg <= stall_sum;
      br_cnt_reg    <= br_sum;
      miss_cnt_reg  <= miss_sum;
    end
  end

  // ---------------- result FSM ----------------
  assign handshake   = (r_state_reg == R_REPORT) && report_ready_i;
  assign snap_accept = (r_state_reg == R_IDLE) || handshake;
  assign load_snap   = snap_fire && snap_accept;
  assign load_report = dividing && (div_cnt_reg == DIV_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state_reg <= R_IDLE;
    else       r_state_reg <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state_reg;
    case (r_state_reg)
      R_IDLE:   if (snap_fire) r_state_next = R_DIVIDE;
      R_DIVIDE: if (div_cnt_reg == DIV_LAST) r_state_next = R_REPORT;
      R_REPORT: if (report_ready_i) r_state_next = snap_fire ? R_DIVIDE : R_IDLE;
      default:  r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    report_valid_o = 1'b0;
    dividing       = 1'b0;
    case (r_state_reg)
      R_DIVIDE: dividing       = 1'b1;
      R_REPORT: report_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Dividend is misses*100; its bits above CNT_WIDTH preload the remainder so the loop stays CNT_WIDTH steps.
  assign mprod    = {7'd0, miss_sum} * PCT_M;
  assign mprod_hi = mprod[MW-1:CNT_WIDTH];

  always_comb begin
    rem_shift = {rem_reg, dvd_reg[CNT_WIDTH-1]};
    rem_diff  = rem_shift[CNT_WIDTH-1:0] - dsr_reg;
    q_bit     = (rem_shift >= {1'b0, dsr_reg});
    rem_step  = q_bit ? rem_diff : rem_shift[CNT_WIDTH-1:0];
    q_step    = {q_reg, q_bit};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      snap_ret_reg   <= '0;
      snap_stall_reg <= '0;
      dvd_reg        <= '0;
      rem_reg        <= '0;
      dsr_reg        <= '0;
      q_reg          <= '0;
      div_cnt_reg    <= '0;
      div_ovf_reg    <= 1'b0;
      div_zero_reg   <= 1'b0;
    end else if (load_snap) begin
      snap_ret_reg   <= ret_sum;
      snap_stall_reg <= stall_sum;
      dvd_reg        <= mprod[CNT_WIDTH-1:0];
      rem_reg        <= {{(CNT_WIDTH-7){1'b0}}, mprod_hi};
      dsr_reg        <= br_sum;
      q_reg          <= '0;
      div_cnt_reg    <= '0;
      div_ovf_reg    <= ({{(CNT_WIDTH-7){1'b0}}, mprod_hi} >= br_sum);
      div_zero_reg   <= (br_sum == '0);
    end else if (dividing) begin
      dvd_reg        <= {dvd_reg[CNT_WIDTH-2:0], 1'b0};
      rem_reg        <= rem_step;
      q_reg          <= q_step[CNT_WIDTH-2:0];
      div_cnt_reg    <= div_cnt_reg + DCW'(1);
    end
  end

  always_comb begin
    ipc_prod    = {32'd0, snap_ret_reg} * IPC_PREC_W;
    ipc_shift   = ipc_prod >> LOG2W;
    ipc_calc    = (|ipc_shift[IPW-1:16]) ? 16'hFFFF : ipc_shift[15:0];
    stall_prod  = {32'd0, snap_stall_reg} * PCT_W;
    stall_shift = stall_prod >> LOG2W;
    stall_calc  = (|stall_shift[IPW-1:8]) ? 8'hFF : stall_shift[7:0];
    if (div_zero_reg)                      bmiss_calc = 8'd0;
    else if (div_ovf_reg || q_step > Q_MAX) bmiss_calc = 8'd100;
    else                                   bmiss_calc = q_step[7:0];
    raw_calc = {bmiss_calc > BMISS_TH, stall_calc > STALL_TH, ipc_calc < IPC_LOW_LIM};
  end

`ifdef RISCV_PERF_WIN_HYST_EN
  logic [2:0] raw_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i)            raw_reg <= '0;
    else if (load_report) raw_reg <= raw_calc;
  end

  // hist_reg: [1] = flag last presented, [0] = raw comparison of last reported window.
  for (genvar gi = 0; gi < 3; gi++) begin : g_hyst
    logic [1:0] hist_reg;
    always_ff @(posedge clk_i) begin
      if (rst_i)          hist_reg <= '0;
      else if (handshake) hist_reg <= {flags_reg[gi], raw_reg[gi]};
    end
    assign flag_calc[gi] = hist_reg[1] ? (raw_calc[gi] | hist_reg[0]) : (raw_calc[gi] & hist_reg[0]);
  end
`else
  assign flag_calc = raw_calc;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ipc_reg   <= '0;
      stall_reg <= '0;
      bmiss_reg <= '0;
      flags_reg <= '0;
    end else if (load_report) begin
      ipc_reg   <= ipc_calc;
      stall_reg <= stall_calc;
      bmiss_reg <= bmiss_calc;
      flags_reg <= flag_calc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                        overrun_reg <= 1'b0;
    else if (snap_fire && !snap_accept) overrun_reg <= 1'b1;
  end

  assign ipc_o        = ipc_reg;
  assign stall_pct_o  = stall_reg;
  assign bmiss_pct_o  = bmiss_reg;
  assign ipc_low_o    = flags_reg[0];
  assign stall_high_o = flags_reg[1];
  assign bmiss_high_o = flags_reg[2];
  assign overrun_o    = overrun_reg;

endmodule
